// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit for a five-stage in-order core.
// Tracks per-stage valid bits, resolves memory waits, taken branches and
// data hazards into stall/flush controls, selects ALU operand forwarding
// and counts stalled fetch cycles (saturating).
// Build option: define HAZARD_CTRL_FORWARD_EN to enable operand forwarding
// with load-use stalls; leave it undefined for a forwarding-free core that
// stalls on every RAW dependence against Execute or Memory.
module hazard_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  Rs1D,
   input  logic [4:0]  Rs2D,
   input  logic [4:0]  Rs1E,
   input  logic [4:0]  Rs2E,
   input  logic [4:0]  RdE,
   input  logic [4:0]  RdM,
   input  logic [4:0]  RdW,
   input  logic        RegWriteE,
   input  logic        RegWriteM,
   input  logic        RegWriteW,
   input  logic [1:0]  ResultSrcE,
   input  logic        PCSrcE,
   input  logic        MemAccessM,
   input  logic        MemReadyM,
   output logic        StallF,
   output logic        StallD,
   output logic        StallE,
   output logic        StallM,
   output logic        FlushD,
   output logic        FlushE,
   output logic        FlushW,
   output logic [1:0]  ForwardAE,
   output logic [1:0]  ForwardBE,
   output logic        ValidW,
   output logic [15:0] StallCnt
);

   typedef enum logic {RUN = 1'b0, MEMWAIT = 1'b1} state_t;

   state_t      state_q, state_d;
   logic        valid_d_q, valid_e_q, valid_m_q, valid_w_q;
   logic        valid_d_d, valid_e_d, valid_m_d, valid_w_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   logic        mem_wait;
   logic        branch;
   logic        data_hazard;
   logic        unused_inputs;

   // Memory wait freezes everything up to Memory and bubbles Writeback.
   assign mem_wait = valid_m_q & MemAccessM & ~MemReadyM;
   // A branch held in Execute during a wait fires as soon as the wait lifts.
   assign branch   = valid_e_q & PCSrcE;

`ifdef HAZARD_CTRL_FORWARD_EN
   logic load_use;
   logic fwd_a_m, fwd_a_w, fwd_b_m, fwd_b_w;

   // Only a load in Execute cannot be bypassed in time for Decode's consumer.
   assign load_use = valid_e_q & (ResultSrcE == 2'b01) & (RdE != 5'd0) &
                     ((RdE == Rs1D) | (RdE == Rs2D));
   assign data_hazard = load_use;

   assign fwd_a_m = valid_m_q & RegWriteM & (RdM != 5'd0) & (RdM == Rs1E);
   assign fwd_a_w = valid_w_q & RegWriteW & (RdW != 5'd0) & (RdW == Rs1E);
   assign fwd_b_m = valid_m_q & RegWriteM & (RdM != 5'd0) & (RdM == Rs2E);
   assign fwd_b_w = valid_w_q & RegWriteW & (RdW != 5'd0) & (RdW == Rs2E);

   // Operand select: Memory is the younger producer, so it wins over Writeback.
   always_comb begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      if (!rst) begin
         if (fwd_a_m)      ForwardAE = 2'b10;
         else if (fwd_a_w) ForwardAE = 2'b01;
         if (fwd_b_m)      ForwardBE = 2'b10;
         else if (fwd_b_w) ForwardBE = 2'b01;
      end
   end

   assign unused_inputs = RegWriteE;
`else
   logic rs1_hit, rs2_hit;

   // Without bypass paths any in-flight writer of a Decode source must drain
   // past Memory; Writeback is covered by the write-first register file.
   assign rs1_hit = (Rs1D != 5'd0) &
                    ((valid_e_q & RegWriteE & (RdE == Rs1D)) |
                     (valid_m_q & RegWriteM & (RdM == Rs1D)));
   assign rs2_hit = (Rs2D != 5'd0) &
                    ((valid_e_q & RegWriteE & (RdE == Rs2D)) |
                     (valid_m_q & RegWriteM & (RdM == Rs2D)));
   assign data_hazard = rs1_hit | rs2_hit;

   assign ForwardAE = 2'b00;
   assign ForwardBE = 2'b00;

   assign unused_inputs = ^{Rs1E, Rs2E, RdW, RegWriteW, ResultSrcE};
`endif

   // Stall/flush priority: memory wait, then branch, then data hazard.
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b0;
      if (!rst) begin
         if (mem_wait) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
         end else if (branch) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
         end else if (data_hazard) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end
      end
   end

   // Valid bits: flush clears, stall holds, otherwise take the upstream bit.
   always_comb begin
      valid_d_d = FlushD ? 1'b0 : (StallD ? valid_d_q : 1'b1);
      valid_e_d = FlushE ? 1'b0 : (StallE ? valid_e_q : valid_d_q);
      valid_m_d = StallM ? valid_m_q : valid_e_q;
      valid_w_d = FlushW ? 1'b0 : valid_m_q;
   end

   // Wait-state tracking: enter on a stalled access, leave once memory is ready.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (mem_wait)  state_d = MEMWAIT;
         MEMWAIT: if (MemReadyM) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // Stall counter saturates rather than wrapping.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (StallF && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
   end

   // State, valid and counter registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         valid_d_q   <= 1'b0;
         valid_e_q   <= 1'b0;
         valid_m_q   <= 1'b0;
         valid_w_q   <= 1'b0;
         stall_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         valid_d_q   <= valid_d_d;
         valid_e_q   <= valid_e_d;
         valid_m_q   <= valid_m_d;
         valid_w_q   <= valid_w_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign ValidW   = valid_w_q & ~FlushW;
   assign StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl. Each stimulus cycle
// pushes the reference model's expected outputs; a negedge monitor pops and
// compares. Model follows HAZARD_CTRL_FORWARD_EN the same way the DUT does.
module tb_hazard_ctrl;

   typedef struct packed {
      logic       rst;
      logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
      logic       rwe, rwm, rww;
      logic [1:0] rse;
      logic       pc, acc, rdy;
   } stim_t;

   typedef struct packed {
      logic        sf, sd, se, sm, fd, fe, fw;
      logic [1:0]  fa, fb;
      logic        vw;
      logic [15:0] cnt;
      logic        quiet;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
   logic        RegWriteE = 1'b0, RegWriteM = 1'b0, RegWriteW = 1'b0;
   logic [1:0]  ResultSrcE = 2'b00;
   logic        PCSrcE = 1'b0, MemAccessM = 1'b0, MemReadyM = 1'b0;
   logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
   logic [1:0]  ForwardAE, ForwardBE;
   logic        ValidW;
   logic [15:0] StallCnt;

   int   total = 0;
   int   passed = 0;
   int   txn = 0;
   exp_t exp_q[$];

   // Reference model state: valid per stage (D,E,M,W) and stall count.
   bit   mv [4];
   int   mcnt = 0;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk(clk), .rst(rst),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
      .MemAccessM(MemAccessM), .MemReadyM(MemReadyM),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ValidW(ValidW), .StallCnt(StallCnt)
   );

   task automatic chk(input string nm, input int act, input int req);
      total++;
      if (act == req) passed++;
      else $display("FAIL %s: got %0d, expected %0d (txn %0d)", nm, act, req, txn);
   endtask

   // Does a live writer of register rd hazard a read of r?
   function automatic bit hit(logic [4:0] r, logic [4:0] rd, bit v, logic we);
      return (r != 5'd0) && v && (we == 1'b1) && (rd == r);
   endfunction

   function automatic logic [1:0] fsel(logic [4:0] rs, stim_t s);
      if (hit(rs, s.rdm, mv[2], s.rwm)) return 2'b10;
      if (hit(rs, s.rdw, mv[3], s.rww)) return 2'b01;
      return 2'b00;
   endfunction

   function automatic exp_t model_out(stim_t s);
      exp_t e = '0;
      bit   mw, br, hz;
      mw = mv[2] && s.acc && !s.rdy;
      br = mv[1] && s.pc;
`ifdef HAZARD_CTRL_FORWARD_EN
      hz = mv[1] && (s.rse == 2'b01) && (s.rde != 5'd0) &&
           ((s.rde == s.rs1d) || (s.rde == s.rs2d));
`else
      hz = hit(s.rs1d, s.rde, mv[1], s.rwe) || hit(s.rs1d, s.rdm, mv[2], s.rwm) ||
           hit(s.rs2d, s.rde, mv[1], s.rwe) || hit(s.rs2d, s.rdm, mv[2], s.rwm);
`endif
      if (s.rst) return e;
      if (mw)      {e.sf, e.sd, e.se, e.sm, e.fw} = 5'b11111;
      else if (br) {e.fd, e.fe} = 2'b11;
      else if (hz) {e.sf, e.sd, e.fe} = 3'b111;
`ifdef HAZARD_CTRL_FORWARD_EN
      e.fa = fsel(s.rs1e, s);
      e.fb = fsel(s.rs2e, s);
`endif
      e.vw  = mv[3] && !e.fw;
      e.cnt = 16'(mcnt);
      return e;
   endfunction

   // Advance the pipeline occupancy by one clock.
   task automatic model_step(input stim_t s, input exp_t e);
      bit up [4];
      bit stl [4];
      bit fl [4];
      bit nv [4];
      if (s.rst) begin
         mv = '{0, 0, 0, 0};
         mcnt = 0;
         return;
      end
      up  = '{1'b1, mv[0], mv[1], mv[2]};
      stl = '{e.sd, e.se, e.sm, 1'b0};
      fl  = '{e.fd, e.fe, 1'b0, e.fw};
      for (int i = 0; i < 4; i++) nv[i] = fl[i] ? 1'b0 : (stl[i] ? mv[i] : up[i]);
      mv = nv;
      if (e.sf && mcnt < 65535) mcnt++;
   endtask

   task automatic apply(input stim_t s, input bit quiet);
      exp_t e;
      @(posedge clk);
      #1;
      rst = s.rst; Rs1D = s.rs1d; Rs2D = s.rs2d; Rs1E = s.rs1e; Rs2E = s.rs2e;
      RdE = s.rde; RdM = s.rdm; RdW = s.rdw;
      RegWriteE = s.rwe; RegWriteM = s.rwm; RegWriteW = s.rww;
      ResultSrcE = s.rse; PCSrcE = s.pc; MemAccessM = s.acc; MemReadyM = s.rdy;
      e = model_out(s);
      e.quiet = quiet;
      exp_q.push_back(e);
      model_step(s, e);
   endtask

   function automatic stim_t rnd_stim();
      stim_t s;
      s.rst  = ($urandom_range(0, 99) < 2);
      s.rs1d = 5'($urandom_range(0, 3)); s.rs2d = 5'($urandom_range(0, 3));
      s.rs1e = 5'($urandom_range(0, 3)); s.rs2e = 5'($urandom_range(0, 3));
      s.rde  = 5'($urandom_range(0, 3)); s.rdm  = 5'($urandom_range(0, 3));
      s.rdw  = 5'($urandom_range(0, 3));
      s.rwe  = 1'($urandom_range(0, 1)); s.rwm = 1'($urandom_range(0, 1));
      s.rww  = 1'($urandom_range(0, 1));
      s.rse  = 2'($urandom_range(0, 3));
      s.pc   = ($urandom_range(0, 99) < 15);
      s.acc  = ($urandom_range(0, 99) < 35);
      s.rdy  = ($urandom_range(0, 99) < 55);
      return s;
   endfunction

   // Monitor: outputs are presented every cycle; compare mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         txn++;
         chk("StallF", int'(StallF), int'(e.sf));
         chk("StallD", int'(StallD), int'(e.sd));
         chk("StallE", int'(StallE), int'(e.se));
         chk("StallM", int'(StallM), int'(e.sm));
         chk("FlushD", int'(FlushD), int'(e.fd));
         chk("FlushE", int'(FlushE), int'(e.fe));
         chk("FlushW", int'(FlushW), int'(e.fw));
         chk("ForwardAE", int'(ForwardAE), int'(e.fa));
         chk("ForwardBE", int'(ForwardBE), int'(e.fb));
         chk("ValidW", int'(ValidW), int'(e.vw));
         chk("StallCnt", int'(StallCnt), int'(e.cnt));
         if (!e.quiet)
            $display("txn %0d rst=%b stall=%b%b%b%b flush=%b%b%b fwd=%b/%b vw=%b cnt=%0d",
                     txn, rst, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                     ForwardAE, ForwardBE, ValidW, StallCnt);
      end
   end

   initial begin
      stim_t s;
      mv = '{0, 0, 0, 0};

      // Reset, then fill the pipe with independent instructions.
      s = '0; s.rst = 1'b1;
      repeat (2) apply(s, 1'b0);
      s = '0;
      repeat (5) apply(s, 1'b0);

      // Forwarding cases: x5 in M, x5 only in W, x0 source against RdM=0.
      s = '0; s.rs1e = 5'd5; s.rdm = 5'd5; s.rwm = 1'b1; apply(s, 1'b0);
      s = '0; s.rs1e = 5'd5; s.rdw = 5'd5; s.rww = 1'b1; apply(s, 1'b0);
      s = '0; s.rs2e = 5'd0; s.rdm = 5'd0; s.rwm = 1'b1; apply(s, 1'b0);

      // Load x6 in Execute with a Decode consumer, then the load moves on.
      s = '0; s.rde = 5'd6; s.rse = 2'b01; s.rwe = 1'b1; s.rs2d = 5'd6; apply(s, 1'b0);
      s = '0; s.rs2e = 5'd6; s.rdw = 5'd6; s.rww = 1'b1; s.rdm = 5'd6; apply(s, 1'b0);
      s = '0; repeat (3) apply(s, 1'b0);

      // Branch together with a load-use: branch wins.
      s = '0; s.pc = 1'b1; s.rde = 5'd7; s.rse = 2'b01; s.rwe = 1'b1; s.rs1d = 5'd7;
      apply(s, 1'b0);
      s = '0; repeat (3) apply(s, 1'b0);

      // Three-cycle memory wait with a branch held in Execute, then ready.
      s = '0; s.acc = 1'b1; s.pc = 1'b1;
      repeat (3) apply(s, 1'b0);
      s.rdy = 1'b1; apply(s, 1'b0);
      s = '0; repeat (4) apply(s, 1'b0);

      // Reset in the middle of a wait, then watch the pipe refill.
      s = '0; s.acc = 1'b1;
      repeat (2) apply(s, 1'b0);
      s.rst = 1'b1; apply(s, 1'b0);
      s = '0; repeat (6) apply(s, 1'b0);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) apply(rnd_stim(), 1'b0);

      // Long wait to drive the counter into saturation.
      s = '0; s.rst = 1'b1; apply(s, 1'b0);
      s = '0; repeat (4) apply(s, 1'b0);
      s = '0; s.acc = 1'b1;
      repeat (65540) apply(s, 1'b1);
      repeat (3) apply(s, 1'b0);
      s.rdy = 1'b1; apply(s, 1'b0);
      s = '0; repeat (3) apply(s, 1'b0);

      // Drain the scoreboard within a bounded number of cycles.
      repeat (4) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         total++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
